sync_shfifo_flex: RTL and testbench

Synchronous show-ahead FIFO for single-clock datapaths. It is the parametrised successor of the team's basic show-ahead FIFO: any depth ≥ 2 (not only powers of two), runtime-programmable almost-empty/almost-full thresholds, write-through-read when full, synchronous flush, peak-occupancy tracking and clearable sticky error flags. It sits between producer and consumer stages that need a combinational head-of-queue view.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_shfifo_mem.sv | 26 ++
 rtl/sync_shfifo_flex.sv | 112 +++++++++++
 tb/tb_sync_shfifo_flex.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO family: width sizing and
// non-power-of-two pointer wrap.
package sync_fifo_pkg;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Increment with explicit wrap at depth-1 so any depth works.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/sync_shfifo_mem.sv
// DEPTH x DW storage: synchronous write, asynchronous read, no reset,
// so it maps onto distributed RAM.
module sync_shfifo_mem #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_shfifo_flex.sv
// Show-ahead FIFO of arbitrary depth with programmable thresholds,
// write-through-read when full, flush, peak tracking and sticky errors.
module sync_shfifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = ptr_w(DEPTH),
    parameter int unsigned CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wen,
    input  logic [DW-1:0] wdat,
    input  logic          ren,
    output logic [DW-1:0] rdat,
    output logic          empty,
    output logic          full,
    output logic          aempty,
    output logic          afull,
    input  logic [CW-1:0] ae_thr,
    input  logic [CW-1:0] af_thr,
    output logic [CW-1:0] level,
    output logic [CW-1:0] free,
    output logic [CW-1:0] peak,
    output logic          ovf_err,
    output logic          udf_err,
    input  logic          err_clr
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] level_nxt, peak_nxt;
    logic          wacc, racc;
    logic          ovf_set, udf_set;
    logic [DW-1:0] mem_rdata;

    sync_shfifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wacc),
        .waddr (wr_ptr),
        .wdata (wdat),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    // Acceptance, pointer/level next-state and error/peak updates.
    always_comb begin
        wacc       = wen & ~flush & (~full | ren);
        racc       = ren & ~flush & ~empty;
        ovf_set    = wen & full & ~ren & ~flush;
        udf_set    = ren & empty & ~flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (wacc) begin
                wr_ptr_nxt = PW'(wrap_inc(32'(wr_ptr), DEPTH));
            end
            if (racc) begin
                rd_ptr_nxt = PW'(wrap_inc(32'(rd_ptr), DEPTH));
            end
            level_nxt = level + CW'(wacc) - CW'(racc);
        end
        if (flush || err_clr) begin
            peak_nxt = level_nxt;
        end else begin
            peak_nxt = (level_nxt > peak) ? level_nxt : peak;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            free    <= DEPTH_C;
            peak    <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            level   <= level_nxt;
            free    <= DEPTH_C - level_nxt;
            peak    <= peak_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == DEPTH_C);
            ovf_err <= ovf_set | (ovf_err & ~err_clr);
            udf_err <= udf_set | (udf_err & ~err_clr);
        end
    end

    // Thresholds are quasi-static inputs compared against the registered level.
    assign aempty = (level <= ae_thr);
    assign afull  = (level >= af_thr);
    assign rdat   = empty ? '0 : mem_rdata;

endmodule

// File: tb/tb_sync_shfifo_flex.sv
// Directed plus randomized bench for sync_shfifo_flex against a queue-based model.
module tb_sync_shfifo_flex;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned PW    = 3;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wen = 1'b0;
    logic [DW-1:0] wdat = '0;
    logic          ren = 1'b0;
    logic [DW-1:0] rdat;
    logic          empty, full, aempty, afull;
    logic [CW-1:0] ae_thr = CW'(1);
    logic [CW-1:0] af_thr = CW'(4);
    logic [CW-1:0] level, free, peak;
    logic          ovf_err, udf_err;
    logic          err_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    int            m_peak = 0;

    sync_shfifo_flex #(.DW(DW), .DEPTH(DEPTH), .PW(PW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wen(wen), .wdat(wdat),
        .ren(ren), .rdat(rdat), .empty(empty), .full(full), .aempty(aempty),
        .afull(afull), .ae_thr(ae_thr), .af_thr(af_thr), .level(level),
        .free(free), .peak(peak), .ovf_err(ovf_err), .udf_err(udf_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        chk({ctx, ":rdat"},   32'(rdat),    (n > 0) ? 32'(q[0]) : 32'd0);
        chk({ctx, ":empty"},  32'(empty),   32'(n == 0));
        chk({ctx, ":full"},   32'(full),    32'(n == DEPTH));
        chk({ctx, ":aempty"}, 32'(aempty),  32'(n <= int'(ae_thr)));
        chk({ctx, ":afull"},  32'(afull),   32'(n >= int'(af_thr)));
        chk({ctx, ":level"},  32'(level),   32'(n));
        chk({ctx, ":free"},   32'(free),    32'(DEPTH - n));
        chk({ctx, ":peak"},   32'(peak),    32'(m_peak));
        chk({ctx, ":ovf"},    32'(ovf_err), 32'(m_ovf));
        chk({ctx, ":udf"},    32'(udf_err), 32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_peak = 0;
    endtask

    // Apply one clock of stimulus, advance the model, then check after the edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                        input logic f, input logic c);
        logic was_full, was_empty;
        wen = w; wdat = d; ren = r; flush = f; err_clr = c;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (f) begin
            q.delete();
            if (c) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            m_peak = 0;
        end else begin
            m_ovf = (w && was_full && !r) || (m_ovf && !c);
            m_udf = (r && was_empty) || (m_udf && !c);
            if (r && !was_empty) void'(q.pop_front());
            if (w && (!was_full || r)) q.push_back(d);
            if (c) m_peak = q.size();
            else if (q.size() > m_peak) m_peak = q.size();
        end
        #1;
        wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
        check_all("step");
    endtask

    initial begin
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill to full, then pop back to empty.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd5);
        chk("fill_free", 32'(free), 32'd0);
        chk("fill_peak", 32'(peak), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("drain_rdat", 32'(rdat), 32'(8'hA0 + i));
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rdat0", 32'(rdat), 32'd0);

        // Refill, then write-through-read while full and overflow attempt.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        wen = 1'b1; ren = 1'b1; wdat = 8'hB0; #1;
        chk("wtr_head", 32'(rdat), 32'hA0);
        step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
        chk("wtr_level", 32'(level), 32'd5);
        chk("wtr_ovf", 32'(ovf_err), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("wrap_rdat", 32'(rdat), (i < 4) ? 32'(8'hA1 + i) : 32'hB0);
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("udf_set", 32'(udf_err), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf_err), 32'd0);
        chk("clr_peak", 32'(peak), 32'd0);

        // Simultaneous write/read on empty: write lands, read flagged.
        step(1'b1, 8'hC5, 1'b1, 1'b0, 1'b0);
        chk("ewr_rdat", 32'(rdat), 32'hC5);
        chk("ewr_udf", 32'(udf_err), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Threshold sweep with a live af_thr change at level 3.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
            if (i == 2) begin
                af_thr = CW'(2); #1;
                chk("afull_live", 32'(afull), 32'd1);
                check_all("thr2");
                af_thr = CW'(4); #1;
                chk("afull_back", 32'(afull), 32'd0);
            end
        end
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush at level 3 with a write pending.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_peak", 32'(peak), 32'd0);

        // Randomized traffic with occasional flush, clear and threshold moves.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                ae_thr = CW'($urandom_range(0, DEPTH));
                af_thr = CW'($urandom_range(0, DEPTH));
            end
            step(1'($urandom_range(0, 99) < 55), DW'($urandom),
                 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 29) == 0));
        end

        // Asynchronous reset mid-stream.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'b0, 1'($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
